multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multicycle RV32 (lw/sw/R-type/I-ALU/beq/jal) control unit. It sits directly upstream of register_file
//  and drives its WE3 (via RegWrite) and the datapath muxes that feed A1/A2/A3/WD3.
//  Moore FSM with a combinational ALU decoder and an immediate-type decoder.
// PARAMETERS
//  none -- ISA-fixed; all encodings live in the package
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  rst         in   1  synchronous, active-low reset (0 = reset)
//  op          in   7  instr[6:0] from instruction register
//  funct3      in   3  instr[14:12]
//  funct7b5    in   1  instr[30]
//  Zero        in   1  ALU zero flag
//  PCWrite     out  1  PC enable = PCUpdate | (Branch & Zero)
//  AdrSrc      out  1  memory address: 0=PC, 1=ALUOut
//  MemWrite    out  1  data memory write enable
//  IRWrite     out  1  instruction register enable
//  ResultSrc   out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA     out  2  00=PC, 01=OldPC, 10=RD1 reg
//  ALUSrcB     out  2  00=RD2 reg, 01=ImmExt, 10=const 4
//  ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  ImmSrc      out  2  00 I, 01 S, 10 B, 11 J (decoded from op only)
//  RegWrite    out  1  drives register_file WE3
// BEHAVIOUR
//  Reset: while rst==0, the next state is FETCH. PCWrite, IRWrite, RegWrite and MemWrite are forced to 0
//   combinationally during reset. After rst rises, the first edge executes FETCH.
//  Outputs not listed for a state are 0. ALUOp is internal; it defaults to 00.
//  FETCH   : IRWrite=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCUpdate=1 -> DECODE
//  DECODE  : ALUSrcA=01, ALUSrcB=01. Next state by op:
//            0000011|0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI;
//            1101111 -> JAL; 1100011 -> BEQ; any other op -> FETCH (no write strobes)
//  MEMADR  : ALUSrcA=10, ALUSrcB=01 -> MEMREAD if op==0000011, else MEMWRITE
//  MEMREAD : AdrSrc=1, ResultSrc=00 -> MEMWB
//  MEMWB   : ResultSrc=01, RegWrite=1 -> FETCH
//  MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 -> FETCH
//  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB
//  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB
//  ALUWB   : ResultSrc=00, RegWrite=1 -> FETCH
//  JAL     : ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 -> ALUWB
//  BEQ     : ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH
//  Instruction latency in clk cycles: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
//  ALU decoder:
//   ALUOp 00 -> add; ALUOp 01 -> sub; ALUOp 11 -> add.
//   ALUOp 10 decodes funct3: 000 -> sub if {op[5],funct7b5}==11, else add; 010 slt; 110 or; 111 and;
//   any other funct3 -> add.
//  ImmSrc is valid in every state. Any op not covered by the I/S/B/J cases -> 00.
//  Unencoded state values (illegal) -> FETCH on the next edge, with all strobes 0 while there.
//  Zero is sampled only in BEQ; it is ignored elsewhere.
// STRUCTURE
//  Package mc_pkg holds:
//   - state_t enum: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, JAL, BEQ
//   - OP_* opcode constants and ALU_* ALUControl constants
//   - IMM_*, RES_*, SRCA_*, SRCB_* mux encodings
//  Sub-module alu_decoder (combinational: ALUOp, funct3, op5, funct7b5 -> ALUControl).
//  The top holds the state register, next-state logic, output decode and ImmSrc decode.
// TESTING
//  1. rst=0 for 3 edges, then 1 -> strobes 0 during reset; cycle 1 after release is FETCH
//     (IRWrite=1, PCWrite=1, ALUSrcB=10).
//  2. op=0000011 (lw) -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
//  3. op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; ALUWB has RegWrite=1.
//     Repeat with funct3=010 -> ALUControl=101.
//  4. op=1100011 in BEQ: Zero=1 -> PCWrite=1; Zero=0 -> PCWrite=0. Either way next state is FETCH.
//  5. op=0100011 (sw) -> MemWrite=1 only in cycle 4, RegWrite never asserts, ImmSrc=01 throughout.
//  6. rst=0 asserted in MEMREAD -> next state is FETCH, no MemWrite/RegWrite pulse. Separately,
//     op=0000000 -> DECODE returns to FETCH with no write strobes.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32 controller: FSM states,
// opcodes, ALU operations and the datapath mux select values.
package mc_pkg;

  // Controller states. Four bits leaves five unencoded values, which the
  // controller treats as illegal and steers back to FETCH.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  // Opcodes (instr[6:0]) of the supported instruction classes
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALUControl encodings seen by the ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Internal ALUOp values passed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // funct3 values the ALU decoder recognises under ALUOP_FUNCT
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  // Immediate format selects for the immediate extender
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Result mux selects
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU source A selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  // ALU source B selects
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: turns the FSM's ALUOp plus the instruction's
// funct fields into the ALUControl code for the ALU.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  // sub only applies to R-type (op5=1) with funct7b5 set; addi is always add
  logic rtypesub;

  assign rtypesub = op5 & funct7b5;

  // Select the ALU operation from ALUOp, falling back to add for anything unlisted
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADDSUB: alucontrol = rtypesub ? ALU_SUB : ALU_ADD;
          F3_SLT:    alucontrol = ALU_SLT;
          F3_OR:     alucontrol = ALU_OR;
          F3_AND:    alucontrol = ALU_AND;
          default:   alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control unit (lw/sw/R-type/I-ALU/beq/jal). Moore FSM that
// sequences the datapath muxes and write enables, plus the immediate-format
// decode and an ALU decoder sub-block.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite
);

  state_t     state;
  state_t     nextstate;

  // Raw per-state strobes before the reset gating is applied
  logic       pcupdate;
  logic       branch;
  logic       irwrites;
  logic       memwrites;
  logic       regwrites;
  logic [1:0] aluop;

  // State register; a low rst parks the FSM in FETCH
  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= nextstate;
  end

  // Next-state logic; DECODE dispatches on opcode, unknown states recover to FETCH
  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH: nextstate = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nextstate = MEMADR;
          OP_RTYPE:     nextstate = EXECUTER;
          OP_ITYPE:     nextstate = EXECUTEI;
          OP_JAL:       nextstate = JAL;
          OP_BEQ:       nextstate = BEQ;
          default:      nextstate = FETCH;
        endcase
      end
      MEMADR:   nextstate = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  nextstate = MEMWB;
      MEMWB:    nextstate = FETCH;
      MEMWRITE: nextstate = FETCH;
      EXECUTER: nextstate = ALUWB;
      EXECUTEI: nextstate = ALUWB;
      ALUWB:    nextstate = FETCH;
      JAL:      nextstate = ALUWB;
      BEQ:      nextstate = FETCH;
      default:  nextstate = FETCH;
    endcase
  end

  // Moore output decode; every control defaults to 0 and each state sets only what it uses
  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    irwrites  = 1'b0;
    memwrites = 1'b0;
    regwrites = 1'b0;
    aluop     = ALUOP_ADD;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_REG;
    case (state)
      FETCH: begin
        irwrites  = 1'b1;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        regwrites = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        memwrites = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_REG;
        aluop   = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ResultSrc = RES_ALUOUT;
        regwrites = 1'b1;
      end
      JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        pcupdate  = 1'b1;
      end
      BEQ: begin
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        aluop     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        branch    = 1'b1;
      end
      default: begin
        pcupdate = 1'b0;
      end
    endcase
  end

  // Immediate format depends only on the opcode, so it is valid in every state
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_SW:   ImmSrc = IMM_S;
      OP_BEQ:  ImmSrc = IMM_B;
      OP_JAL:  ImmSrc = IMM_J;
      default: ImmSrc = IMM_I;
    endcase
  end

  // Write strobes are held off combinationally while rst is low; Zero only
  // matters when branch is raised, which happens in BEQ alone
  assign PCWrite  = rst & (pcupdate | (branch & Zero));
  assign IRWrite  = rst & irwrites;
  assign MemWrite = rst & memwrites;
  assign RegWrite = rst & regwrites;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each stimulus cycle pushes the
// hand-derived expected output word; a negedge monitor pops and compares.
module tb_multicycle_controller;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RTYPE = 7'b0110011;
  localparam logic [6:0] ITYPE = 7'b0010011;
  localparam logic [6:0] JALOP = 7'b1101111;
  localparam logic [6:0] BEQOP = 7'b1100011;
  localparam logic [6:0] BAD   = 7'b0000000;

  localparam logic [1:0] IMMI = 2'b00;
  localparam logic [1:0] IMMS = 2'b01;
  localparam logic [1:0] IMMB = 2'b10;
  localparam logic [1:0] IMMJ = 2'b11;

  typedef struct {
    logic [15:0] vec;
    string       name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  logic       curRst;
  logic [6:0] curOp;
  logic [2:0] curF3;
  logic       curF7;
  logic       curZero;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  logic [15:0] act;

  multicycle_controller dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUControl (ALUControl),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite)
  );

  always #5 clk = ~clk;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, RegWrite};

  // Output word layout: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB ALUControl ImmSrc RegWrite
  function automatic logic [15:0] pack(input logic pcw, input logic adr,
                                       input logic mw, input logic irw,
                                       input logic [1:0] res, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [1:0] imm, input logic rw);
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw};
  endfunction

  function automatic logic [15:0] eReset(input logic [1:0] imm);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eFetch(input logic [1:0] imm);
    return pack(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eDecode(input logic [1:0] imm);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eMemAdr(input logic [1:0] imm);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eMemRead(input logic [1:0] imm);
    return pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eMemWb(input logic [1:0] imm);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1'b1);
  endfunction
  function automatic logic [15:0] eMemWrite(input logic [1:0] imm);
    return pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eExecR(input logic [1:0] imm, input logic [2:0] alu);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, alu, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eExecI(input logic [1:0] imm, input logic [2:0] alu);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, alu, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eAluWb(input logic [1:0] imm);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1);
  endfunction
  function automatic logic [15:0] eJal(input logic [1:0] imm);
    return pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, imm, 1'b0);
  endfunction
  function automatic logic [15:0] eBeq(input logic [1:0] imm, input logic pcw);
    return pack(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 1'b0);
  endfunction

  // Latch the inputs to drive on the following stimulus cycles
  task automatic setIn(input logic r, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z);
    curRst  = r;
    curOp   = o;
    curF3   = f3;
    curF7   = f7;
    curZero = z;
  endtask

  // Drive one cycle just after the rising edge and queue its expected outputs
  task automatic applyStimulus(input logic [15:0] vec, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst      = curRst;
    op       = curOp;
    funct3   = curF3;
    funct7b5 = curF7;
    Zero     = curZero;
    e.vec    = vec;
    e.name   = name;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (act !== e.vec) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.vec);
    end
  endtask

  // Full four-cycle ALU instruction, checking ALUControl in its execute state
  task automatic runAlu(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [2:0] alu, input string name);
    setIn(1'b1, o, f3, f7, 1'b0);
    applyStimulus(eFetch(IMMI), {name, " fetch"});
    applyStimulus(eDecode(IMMI), {name, " decode"});
    if (o == RTYPE) applyStimulus(eExecR(IMMI, alu), {name, " executer"});
    else            applyStimulus(eExecI(IMMI, alu), {name, " executei"});
    applyStimulus(eAluWb(IMMI), {name, " aluwb"});
  endtask

  // Monitor: pop and compare one expected word per cycle, mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; op = BAD; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;

    // Reset held for three edges, then released into FETCH
    setIn(1'b0, LW, 3'b010, 1'b0, 1'b0);
    repeat (3) applyStimulus(eReset(IMMI), "reset");

    // lw: five cycles, RegWrite only in MEMWB
    setIn(1'b1, LW, 3'b010, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMI), "lw fetch");
    applyStimulus(eDecode(IMMI), "lw decode");
    applyStimulus(eMemAdr(IMMI), "lw memadr");
    applyStimulus(eMemRead(IMMI), "lw memread");
    applyStimulus(eMemWb(IMMI), "lw memwb");

    // ALU decoder coverage through R-type and I-type instructions
    runAlu(RTYPE, 3'b000, 1'b1, 3'b001, "sub");
    runAlu(RTYPE, 3'b010, 1'b0, 3'b101, "slt");
    runAlu(RTYPE, 3'b000, 1'b0, 3'b000, "add");
    runAlu(RTYPE, 3'b001, 1'b0, 3'b000, "sll as add");
    runAlu(ITYPE, 3'b000, 1'b1, 3'b000, "addi f7b5");
    runAlu(ITYPE, 3'b110, 1'b0, 3'b011, "ori");
    runAlu(ITYPE, 3'b111, 1'b0, 3'b010, "andi");

    // beq taken and not taken; Zero must not leak into DECODE
    setIn(1'b1, BEQOP, 3'b000, 1'b0, 1'b1);
    applyStimulus(eFetch(IMMB), "beq1 fetch");
    applyStimulus(eDecode(IMMB), "beq1 decode");
    applyStimulus(eBeq(IMMB, 1'b1), "beq taken");
    setIn(1'b1, BEQOP, 3'b000, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMB), "beq0 fetch");
    applyStimulus(eDecode(IMMB), "beq0 decode");
    applyStimulus(eBeq(IMMB, 1'b0), "beq not taken");

    // sw: MemWrite only in MEMWRITE, S immediate throughout
    setIn(1'b1, SW, 3'b010, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMS), "sw fetch");
    applyStimulus(eDecode(IMMS), "sw decode");
    applyStimulus(eMemAdr(IMMS), "sw memadr");
    applyStimulus(eMemWrite(IMMS), "sw memwrite");

    // jal: PC update in JAL then write-back
    setIn(1'b1, JALOP, 3'b000, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMJ), "jal fetch");
    applyStimulus(eDecode(IMMJ), "jal decode");
    applyStimulus(eJal(IMMJ), "jal jal");
    applyStimulus(eAluWb(IMMJ), "jal aluwb");

    // Reset asserted during MEMREAD must skip MEMWB and land in FETCH
    setIn(1'b1, LW, 3'b010, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMI), "lw2 fetch");
    applyStimulus(eDecode(IMMI), "lw2 decode");
    applyStimulus(eMemAdr(IMMI), "lw2 memadr");
    setIn(1'b0, LW, 3'b010, 1'b0, 1'b0);
    applyStimulus(eMemRead(IMMI), "lw2 memread in reset");

    // Illegal opcode: DECODE returns straight to FETCH
    setIn(1'b1, BAD, 3'b000, 1'b0, 1'b0);
    applyStimulus(eFetch(IMMI), "fetch after reset");
    applyStimulus(eDecode(IMMI), "illegal decode");
    applyStimulus(eFetch(IMMI), "illegal back to fetch");
    applyStimulus(eDecode(IMMI), "illegal decode again");

    for (int i = 0; i < 5 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
